// File: rtl/wall_gen_pkg.sv
// Shared types and constants for the wall-height generator: FSM states and
// maximal-length LFSR tap masks for widths 3..16.
package wall_gen_pkg;

    typedef enum logic [1:0] {
        SHIFT,
        MAP,
        HOLD
    } wall_state_e;

    // Fibonacci masks: bit k-1 set for each x^k term, feedback = ^(lfsr & mask).
    function automatic logic [15:0] lfsr_taps(input int unsigned width);
        logic [15:0] m;
        case (width)
            3:       m = 16'h0006;
            4:       m = 16'h000C;
            5:       m = 16'h0014;
            6:       m = 16'h0030;
            7:       m = 16'h0060;
            8:       m = 16'h00B8;
            9:       m = 16'h0110;
            10:      m = 16'h0240;
            11:      m = 16'h0500;
            12:      m = 16'h0829;
            13:      m = 16'h100D;
            14:      m = 16'h2015;
            15:      m = 16'h6000;
            16:      m = 16'hD008;
            default: m = 16'h0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/wall_height_lfsr_gen_lfsr_core.sv
// Fibonacci LFSR register with synchronous load and an all-zero recovery guard.
module lfsr_core #(
    parameter int unsigned    W        = 8,
    parameter logic [W-1:0]   TAP_MASK = '0,
    parameter logic [W-1:0]   SEED_VAL = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         shift_en,
    output logic [W-1:0] state
);

    logic [W-1:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = load_val;
        end else if (shift_en) begin
            // All-zero is a fixed point of XOR feedback; restart from the seed.
            if (lfsr_q == '0) begin
                lfsr_d = SEED_VAL;
            end else begin
                lfsr_d = {lfsr_q[W-2:0], ^(lfsr_q & TAP_MASK)};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= SEED_VAL;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state = lfsr_q;

endmodule

// File: rtl/wall_height_lfsr_gen.sv
// Pseudo-random wall height source: LFSR stepped STEPS times per sample, mapped
// into [MIN_H, MAX_H], optionally slew-limited, delivered over valid/ready.
module wall_height_lfsr_gen
    import wall_gen_pkg::*;
#(
    parameter int unsigned LFSR_W    = 8,
    parameter int unsigned STEPS     = LFSR_W,
    parameter int unsigned SEED      = 1,
    parameter int unsigned OUT_W     = 8,
    parameter int unsigned MIN_H     = 0,
    parameter int unsigned MAX_H     = 90,
    parameter int unsigned MAX_DELTA = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_in,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [OUT_W-1:0]  height
);

    localparam logic [LFSR_W-1:0] TAP_MASK  = LFSR_W'(lfsr_taps(LFSR_W));
    localparam logic [LFSR_W-1:0] SEED_V    = LFSR_W'(SEED);
    localparam int unsigned       SPAN      = MAX_H - MIN_H + 1;
    localparam int unsigned       PW        = LFSR_W + OUT_W + 1;
    localparam logic [7:0]        LAST_STEP = 8'(STEPS - 1);

    if (LFSR_W < 3 || LFSR_W > 16) begin : g_bad_width
        $error("LFSR_W must be in 3..16");
    end
    if (STEPS < 1 || STEPS > 255) begin : g_bad_steps
        $error("STEPS must be in 1..255");
    end
    if (SEED == 0 || SEED >= (1 << LFSR_W)) begin : g_bad_seed
        $error("SEED must be nonzero and fit in LFSR_W bits");
    end
    if (MIN_H > MAX_H || MAX_H >= (1 << OUT_W)) begin : g_bad_range
        $error("require MIN_H <= MAX_H < 2**OUT_W");
    end

    wall_state_e       state_q, state_d;
    logic [7:0]        step_q, step_d;
    logic [OUT_W-1:0]  height_q, height_d;
    logic [OUT_W-1:0]  prev_q, prev_d;
    logic              first_q, first_d;

    logic [LFSR_W-1:0] lfsr;
    logic [LFSR_W-1:0] load_val;
    logic [PW-1:0]     prod;
    int                raw_i;
    int                lim_i;
    logic [OUT_W-1:0]  map_h;

    assign load_val = (seed_in == '0) ? SEED_V : seed_in;

    lfsr_core #(
        .W        (LFSR_W),
        .TAP_MASK (TAP_MASK),
        .SEED_VAL (SEED_V)
    ) u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .load     (seed_load),
        .load_val (load_val),
        .shift_en (state_q == SHIFT),
        .state    (lfsr)
    );

    always_comb begin
        prod  = PW'(lfsr) * PW'(SPAN);
        raw_i = int'(MIN_H) + int'(prod >> LFSR_W);
        lim_i = raw_i;
        // Signed window around prev so prev - MAX_DELTA cannot wrap below zero.
        if (MAX_DELTA != 0 && !first_q) begin
            if (lim_i < int'(prev_q) - int'(MAX_DELTA)) lim_i = int'(prev_q) - int'(MAX_DELTA);
            if (lim_i > int'(prev_q) + int'(MAX_DELTA)) lim_i = int'(prev_q) + int'(MAX_DELTA);
            if (lim_i < int'(MIN_H)) lim_i = int'(MIN_H);
            if (lim_i > int'(MAX_H)) lim_i = int'(MAX_H);
        end
        map_h = OUT_W'(lim_i);
    end

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        height_d = height_q;
        prev_d   = prev_q;
        first_d  = first_q;
        case (state_q)
            SHIFT: begin
                if (step_q == LAST_STEP) begin
                    step_d  = '0;
                    state_d = MAP;
                end else begin
                    step_d = step_q + 8'd1;
                end
            end
            MAP: begin
                height_d = map_h;
                prev_d   = map_h;
                first_d  = 1'b0;
                state_d  = HOLD;
            end
            HOLD: begin
                if (out_ready) state_d = SHIFT;
            end
            default: state_d = SHIFT;
        endcase
        if (seed_load) begin
            state_d = SHIFT;
            step_d  = '0;
            first_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= SHIFT;
            step_q   <= '0;
            height_q <= OUT_W'(MIN_H);
            prev_q   <= OUT_W'(MIN_H);
            first_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            height_q <= height_d;
            prev_q   <= prev_d;
            first_q  <= first_d;
        end
    end

    assign out_valid = (state_q == HOLD);
    assign height    = height_q;

endmodule
